ev19_soc_keys: RTL and testbench

EV19_SOC_KEYS -- requirements
Module: ev19_soc_keys

---
 rtl/ev19_soc_keys.sv | 113 +++++++++++
 tb/tb_ev19_soc_keys.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ev19_soc_keys.sv
// Debounced key/switch input port with Avalon-MM registers and edge-capture interrupt.
// Read latency 1 cycle; no wait states, bus never stalls debouncing.
module ev19_soc_keys #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] r_irq_mask;
    logic [15:0]      r_cnt [WIDTH];

    logic             w_wr;
    logic [WIDTH-1:0] w_upd;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    assign w_wr     = chipselect & ~write_n;
    assign w_unused = &{1'b0, writedata[31:WIDTH]};

    // A bit is accepted once it has disagreed with stable for DEBOUNCE_CYCLES cycles.
    always_comb begin
        w_upd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_upd[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
        end
    end

    always_comb begin
        if (EDGE_TYPE == 0)
            w_set = w_upd & r_sync2;
        else if (EDGE_TYPE == 1)
            w_set = w_upd & ~r_sync2;
        else
            w_set = w_upd;
    end

    assign w_clr = (w_wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rd_mux = '0;
        case (address)
            3'd0:    w_rd_mux = 32'(r_stable);
            3'd2:    w_rd_mux = 32'(r_irq_mask);
            3'd3:    w_rd_mux = 32'(r_edge_cap);
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_upd[i]) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end
            end
        end
    end

    // Set wins over a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cap <= '0;
            r_irq_mask <= '0;
            readdata   <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_set;
            if (w_wr && address == 3'd2)
                r_irq_mask <= writedata[WIDTH-1:0];
            readdata <= w_rd_mux;
        end
    end

    assign irq = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_ev19_soc_keys.sv
// Directed plus randomized bench for ev19_soc_keys, EDGE_TYPE 1 and 2 side by side.
module tb_ev19_soc_keys;

    localparam int W = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic [31:0] rd1, rd2;
    logic        irq1, irq2;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: stable value, captures per edge flavour, mask, expected reads
    logic [W-1:0] m_s1, m_s2, m_stab, m_cap1, m_cap2, m_mask;
    logic [31:0]  m_rd1, m_rd2;
    logic [W-1:0] hist[$];

    always #5 clk = ~clk;

    ev19_soc_keys #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1));

    ev19_soc_keys #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2));

    function automatic logic [31:0] rdval(input logic [2:0] a, input logic [W-1:0] stab,
                                          input logic [W-1:0] mask, input logic [W-1:0] cap);
        case (a)
            3'd0:    return {28'b0, stab};
            3'd2:    return {28'b0, mask};
            3'd3:    return {28'b0, cap};
            default: return 32'b0;
        endcase
    endfunction

    task automatic model_reset;
        m_s1 = '0; m_s2 = '0; m_stab = '0; m_cap1 = '0; m_cap2 = '0; m_mask = '0;
        m_rd1 = '0; m_rd2 = '0;
        hist.delete();
    endtask

    // A bit flips when the last D synchronized samples all oppose the current stable value.
    task automatic model_step;
        logic [W-1:0] nst, rise, fall, clr;
        bit all_opp;
        m_rd1 = rdval(address, m_stab, m_mask, m_cap1);
        m_rd2 = rdval(address, m_stab, m_mask, m_cap2);
        hist.push_back(m_s2);
        if (hist.size() > D) void'(hist.pop_front());
        nst = m_stab;
        if (hist.size() == D) begin
            for (int i = 0; i < W; i++) begin
                all_opp = 1'b1;
                foreach (hist[k]) if (hist[k][i] == m_stab[i]) all_opp = 1'b0;
                if (all_opp) nst[i] = ~m_stab[i];
            end
        end
        rise = nst & ~m_stab;
        fall = ~nst & m_stab;
        clr  = (chipselect && !write_n && address == 3'd3) ? writedata[W-1:0] : '0;
        if (chipselect && !write_n && address == 3'd2) m_mask = writedata[W-1:0];
        m_cap1 = (m_cap1 & ~clr) | fall;
        m_cap2 = (m_cap2 & ~clr) | rise | fall;
        m_stab = nst;
        m_s2   = m_s1;
        m_s1   = in_port;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs;
        check("rd_fall", rd1, m_rd1);
        check("rd_any", rd2, m_rd2);
        check("irq_fall", {31'b0, irq1}, {31'b0, |(m_cap1 & m_mask)});
        check("irq_any", {31'b0, irq2}, {31'b0, |(m_cap2 & m_mask)});
    endtask

    task automatic tick;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = 4'hF;
        model_reset();
        @(negedge clk); @(negedge clk);
        check("reset_rd", rd1, 32'h0);
        check("reset_irq", {31'b0, irq1}, 32'h0);
        reset_n = 1'b1;

        // Keys high out of reset: stable updates on the 6th edge
        ticks(6);
        check("data_edge6_old", rd1, 32'h0);
        tick();
        check("data_edge7_F", rd1, 32'hF);
        address = 3'd3;
        tick();
        check("cap_fall_none", rd1, 32'h0);
        check("cap_any_rise", rd2, 32'hF);
        bus_write(3'd3, 32'hF);

        // Short glitch is rejected, long press is accepted
        address = 3'd0;
        in_port = 4'hE; ticks(3);
        in_port = 4'hF; ticks(10);
        check("glitch_rejected", rd1, 32'hF);
        in_port = 4'hE; ticks(6);
        check("press_edge6_old", rd1, 32'hF);
        tick();
        check("press_edge7_E", rd1, 32'hE);
        address = 3'd3; tick();
        check("press_cap", rd1, 32'h1);

        // Mask then clear
        bus_write(3'd2, 32'h1);
        check("irq_masked_on", {31'b0, irq1}, 32'h1);
        bus_write(3'd3, 32'h1);
        check("irq_cleared", {31'b0, irq1}, 32'h0);

        // Clear write coincides with a new capture on bit0
        in_port = 4'hF; ticks(10);
        in_port = 4'hE; ticks(5);
        bus_write(3'd3, 32'h1);
        address = 3'd3; tick();
        check("set_beats_clear", {31'b0, rd1[0]}, 32'h1);

        // Any-edge capture on bit3 with mask 0
        bus_write(3'd2, 32'h0);
        in_port = 4'h6; ticks(10);
        bus_write(3'd3, 32'hF);
        in_port = 4'hE; ticks(10);
        address = 3'd3; tick();
        check("any_rise_b3", {31'b0, rd2[3]}, 32'h1);
        bus_write(3'd3, 32'h8);
        in_port = 4'h6; ticks(10);
        address = 3'd3; tick();
        check("any_fall_b3", {31'b0, rd2[3]}, 32'h1);
        check("any_irq_masked", {31'b0, irq2}, 32'h0);

        // Randomized pins, holds and bus traffic
        for (int s = 0; s < 80; s++) begin
            in_port = W'($urandom);
            for (int h = $urandom_range(1, 8); h > 0; h--) begin
                address    = 3'($urandom_range(0, 7));
                writedata  = $urandom;
                chipselect = ($urandom_range(0, 3) == 0);
                write_n    = ($urandom_range(0, 1) == 0);
                tick();
            end
        end
        chipselect = 1'b0; write_n = 1'b1;

        // Reset in the middle of a debounce count
        address = 3'd0;
        in_port = 4'h0; ticks(12);
        in_port = 4'hF; ticks(4);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("midreset_rd", rd1, 32'h0);
        check("midreset_rd_any", rd2, 32'h0);
        check("midreset_irq", {31'b0, irq1 | irq2}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        ticks(6);
        check("restart_edge6_old", rd1, 32'h0);
        tick();
        check("restart_edge7_F", rd1, 32'hF);
        ticks(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
